// File: rtl/ball_tracker.sv
// ball_tracker
//
// Moves a ball one maze cell at a time in the direction of the board tilt.
// A movement tick is generated every STEP_DIV clocks while the tracker is
// enabled. Each tick with enough tilt looks up the wall bit of the
// neighbouring cell and then either moves the ball there or sends it back to
// the start cell (1,1) on a wall hit. Reaching the finish cell
// (GRID_W-2, GRID_H-2) freezes the tracker until the next game_start.
//
// Ports
//   clk           system clock, all logic on its rising edge
//   rst           asynchronous active-high reset
//   game_start    one-cycle pulse: reload the start cell, latch level, enable motion
//   level[1:0]    level select, sampled on game_start
//   tilt_x[7:0]   signed accelerometer X reading
//   tilt_y[7:0]   signed accelerometer Y reading
//   tilt_valid    tilt_x/tilt_y are valid and get captured this cycle
//   wall_rd_addr  maze memory address {level, cand_y[4:0], cand_x[5:0]}
//   wall_rd_data  wall bit for last cycle's wall_rd_addr (1 = wall)
//   ball_x[5:0]   current ball column
//   ball_y[4:0]   current ball row
//   moving        captured tilt is outside the dead zone and tracker enabled
//   collision     one-cycle pulse on a wall hit
//   at_finish     high while the ball rests on the finish cell
module ball_tracker #(
   parameter int STEP_DIV = 2500000,
   parameter int DEADZONE = 16,
   parameter int GRID_W   = 40,
   parameter int GRID_H   = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        game_start,
   input  logic [1:0]  level,
   input  logic [7:0]  tilt_x,
   input  logic [7:0]  tilt_y,
   input  logic        tilt_valid,
   output logic [12:0] wall_rd_addr,
   input  logic        wall_rd_data,
   output logic [5:0]  ball_x,
   output logic [4:0]  ball_y,
   output logic        moving,
   output logic        collision,
   output logic        at_finish
);

   localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(STEP_DIV - 1);
   localparam logic [8:0] DZ    = 9'(DEADZONE);
   localparam logic [6:0] X_MAX = 7'(GRID_W - 1);
   localparam logic [5:0] Y_MAX = 6'(GRID_H - 1);
   localparam logic [5:0] FIN_X = 6'(GRID_W - 2);
   localparam logic [4:0] FIN_Y = 5'(GRID_H - 2);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TICK,
      LOOKUP,
      CHECK,
      UPDATE,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [1:0]       level_q;
   logic [CNT_W-1:0] tick_cnt;
   logic [7:0]       tilt_x_q, tilt_y_q;
   logic [5:0]       cand_x;
   logic [4:0]       cand_y;
   logic             cand_blocked;

   logic [8:0] mag_x, mag_y;
   logic       tilt_active, use_x, step_neg, enabled, tick_last;
   logic [6:0] nxt_x;
   logic [5:0] nxt_y;
   logic       nxt_blocked;
   logic       start_lookup, hit, advance;

   // Magnitudes are widened to 9 bits so that -128 compares as 128.
   assign mag_x = tilt_x_q[7] ? (9'd0 - {1'b1, tilt_x_q}) : {1'b0, tilt_x_q};
   assign mag_y = tilt_y_q[7] ? (9'd0 - {1'b1, tilt_y_q}) : {1'b0, tilt_y_q};

   assign tilt_active = (mag_x >= DZ) || (mag_y >= DZ);
   assign enabled     = (state == WAIT_TICK) || (state == LOOKUP) ||
                        (state == CHECK)     || (state == UPDATE);
   assign moving      = enabled && tilt_active;
   assign at_finish   = (state == DONE);
   assign tick_last   = (tick_cnt == TICK_LAST);

   // Dominant axis wins, ties go to X. Stepping below zero wraps to an
   // all-ones value, so one unsigned upper-bound compare covers both edges.
   always_comb begin
      use_x    = (mag_x >= mag_y);
      step_neg = use_x ? tilt_x_q[7] : tilt_y_q[7];
      nxt_x    = {1'b0, ball_x};
      nxt_y    = {1'b0, ball_y};
      if (use_x) begin
         nxt_x = step_neg ? ({1'b0, ball_x} - 7'd1) : ({1'b0, ball_x} + 7'd1);
      end else begin
         nxt_y = step_neg ? ({1'b0, ball_y} - 6'd1) : ({1'b0, ball_y} + 6'd1);
      end
      nxt_blocked = (nxt_x > X_MAX) || (nxt_y > Y_MAX);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the step strobes that drive the datapath. A
   // game_start cancels whatever step is in flight, including a wall hit or
   // ball update that would otherwise land on the same edge.
   always_comb begin
      state_nxt    = state;
      start_lookup = 1'b0;
      hit          = 1'b0;
      advance      = 1'b0;
      case (state)
         IDLE: begin
            if (game_start) state_nxt = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (tick_last && moving) begin
               state_nxt    = LOOKUP;
               start_lookup = 1'b1;
            end
         end
         LOOKUP: begin
            state_nxt = cand_blocked ? WAIT_TICK : CHECK;
         end
         CHECK: begin
            if (wall_rd_data) begin
               state_nxt = WAIT_TICK;
               hit       = 1'b1;
            end else begin
               state_nxt = UPDATE;
            end
         end
         UPDATE: begin
            advance   = 1'b1;
            state_nxt = ((cand_x == FIN_X) && (cand_y == FIN_Y)) ? DONE : WAIT_TICK;
         end
         DONE: begin
            if (game_start) state_nxt = WAIT_TICK;
         end
         default: state_nxt = IDLE;
      endcase
      if (game_start) begin
         state_nxt    = WAIT_TICK;
         start_lookup = 1'b0;
         hit          = 1'b0;
         advance      = 1'b0;
      end
   end

   // Datapath. The candidate is latched at the tick so a tilt capture
   // during the step cannot change where the ball goes; the memory address
   // is only driven for in-grid candidates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q      <= 2'd0;
         tick_cnt     <= '0;
         tilt_x_q     <= 8'd0;
         tilt_y_q     <= 8'd0;
         cand_x       <= 6'd1;
         cand_y       <= 5'd1;
         cand_blocked <= 1'b0;
         wall_rd_addr <= 13'd0;
         ball_x       <= 6'd1;
         ball_y       <= 5'd1;
         collision    <= 1'b0;
      end else begin
         collision <= 1'b0;
         if (tilt_valid) begin
            tilt_x_q <= tilt_x;
            tilt_y_q <= tilt_y;
         end
         if (game_start) begin
            ball_x   <= 6'd1;
            ball_y   <= 5'd1;
            level_q  <= level;
            tick_cnt <= '0;
         end else begin
            if (state == WAIT_TICK) begin
               tick_cnt <= tick_last ? '0 : CNT_W'(tick_cnt + 1'b1);
            end
            if (start_lookup) begin
               cand_x       <= nxt_x[5:0];
               cand_y       <= nxt_y[4:0];
               cand_blocked <= nxt_blocked;
               if (!nxt_blocked) begin
                  wall_rd_addr <= {level_q, nxt_y[4:0], nxt_x[5:0]};
               end
            end
            if (hit) begin
               collision <= 1'b1;
               ball_x    <= 6'd1;
               ball_y    <= 5'd1;
            end
            if (advance) begin
               ball_x <= cand_x;
               ball_y <= cand_y;
            end
         end
      end
   end

endmodule

// File: tb/tb_ball_tracker.sv
// tb_ball_tracker
//
// Directed bench for ball_tracker with STEP_DIV=4 and the default 40x30 grid.
// A table of single-step vectors covers direction selection, dead zone,
// addressing and wall hits; hand-written sequences cover multi-step motion,
// edge blocking, collision pulse width, the finish cell, game_start abort
// and reset during a wall check. The maze memory is a 1-cycle-latency array.
module tb_ball_tracker;

   logic        clk;
   logic        rst;
   logic        game_start;
   logic [1:0]  level;
   logic [7:0]  tilt_x;
   logic [7:0]  tilt_y;
   logic        tilt_valid;
   logic [12:0] wall_rd_addr;
   logic        wall_rd_data;
   logic [5:0]  ball_x;
   logic [4:0]  ball_y;
   logic        moving;
   logic        collision;
   logic        at_finish;

   int checks = 0;
   int errors = 0;

   logic wall_mem [0:8191];

   ball_tracker #(
      .STEP_DIV (4),
      .DEADZONE (16),
      .GRID_W   (40),
      .GRID_H   (30)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .game_start   (game_start),
      .level        (level),
      .tilt_x       (tilt_x),
      .tilt_y       (tilt_y),
      .tilt_valid   (tilt_valid),
      .wall_rd_addr (wall_rd_addr),
      .wall_rd_data (wall_rd_data),
      .ball_x       (ball_x),
      .ball_y       (ball_y),
      .moving       (moving),
      .collision    (collision),
      .at_finish    (at_finish)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Maze memory with one cycle of read latency.
   always @(posedge clk) wall_rd_data <= wall_mem[wall_rd_addr];

   // Hard stop in case some wait never returns.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [7:0]  tx;
      logic [7:0]  ty;
      logic [1:0]  lvl;
      logic        has_wall;
      logic [12:0] wall_addr;
      logic [5:0]  exp_x;
      logic [4:0]  exp_y;
      logic        exp_coll;
      logic        exp_moving;
      logic        check_addr;
      logic [12:0] exp_addr;
   } vec_t;

   vec_t vecs [14];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic tickNeg();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst        = 1'b1;
      game_start = 1'b0;
      tilt_valid = 1'b0;
      tickNeg();
      tickNeg();
      rst = 1'b0;
   endtask

   task automatic applyTilt(input logic [7:0] tx, input logic [7:0] ty);
      tilt_x     = tx;
      tilt_y     = ty;
      tilt_valid = 1'b1;
      tickNeg();
      tilt_valid = 1'b0;
   endtask

   task automatic startGame(input logic [1:0] lvl);
      level      = lvl;
      game_start = 1'b1;
      tickNeg();
      game_start = 1'b0;
   endtask

   // Waits (bounded) until the DUT drives the given lookup address.
   task automatic waitAddr(input string name, input logic [12:0] target);
      int n = 0;
      while (wall_rd_addr !== target && n < 100) begin
         tickNeg();
         n++;
      end
      checkOutput(name, wall_rd_addr, target);
   endtask

   // One table vector: fresh game, then 9 cycles covers exactly one step.
   task automatic applyStimulus(input int idx);
      logic coll_seen;
      vec_t v;
      v = vecs[idx];
      if (v.has_wall) wall_mem[v.wall_addr] = 1'b1;
      applyTilt(v.tx, v.ty);
      startGame(v.lvl);
      coll_seen = 1'b0;
      for (int k = 0; k < 9; k++) begin
         tickNeg();
         if (collision) coll_seen = 1'b1;
      end
      checkOutput($sformatf("vec%0d_ball_x", idx), ball_x, v.exp_x);
      checkOutput($sformatf("vec%0d_ball_y", idx), ball_y, v.exp_y);
      checkOutput($sformatf("vec%0d_collision", idx), coll_seen, v.exp_coll);
      checkOutput($sformatf("vec%0d_moving", idx), moving, v.exp_moving);
      if (v.check_addr) checkOutput($sformatf("vec%0d_addr", idx), wall_rd_addr, v.exp_addr);
      if (v.has_wall) wall_mem[v.wall_addr] = 1'b0;
   endtask

   initial begin
      logic coll_seen;
      int n;

      for (int i = 0; i < 8192; i++) wall_mem[i] = 1'b0;

      //            tx     ty     lvl  wall  waddr     x     y    col  mov  chk  addr
      vecs[0]  = '{8'd40,  8'd0,   2'd0, 1'b0, 13'h0,    6'd2, 5'd1, 1'b0, 1'b1, 1'b1, 13'h0042};
      vecs[1]  = '{8'hD8,  8'd0,   2'd3, 1'b0, 13'h0,    6'd0, 5'd1, 1'b0, 1'b1, 1'b1, 13'h1840};
      vecs[2]  = '{8'd0,   8'd40,  2'd2, 1'b0, 13'h0,    6'd1, 5'd2, 1'b0, 1'b1, 1'b1, 13'h1081};
      vecs[3]  = '{8'd0,   8'hD8,  2'd0, 1'b0, 13'h0,    6'd1, 5'd0, 1'b0, 1'b1, 1'b1, 13'h0001};
      vecs[4]  = '{8'd30,  8'd30,  2'd0, 1'b0, 13'h0,    6'd2, 5'd1, 1'b0, 1'b1, 1'b1, 13'h0042};
      vecs[5]  = '{8'hE2,  8'd30,  2'd0, 1'b0, 13'h0,    6'd0, 5'd1, 1'b0, 1'b1, 1'b1, 13'h0040};
      vecs[6]  = '{8'd20,  8'hCE,  2'd0, 1'b0, 13'h0,    6'd1, 5'd0, 1'b0, 1'b1, 1'b1, 13'h0001};
      vecs[7]  = '{8'h80,  8'd127, 2'd0, 1'b0, 13'h0,    6'd0, 5'd1, 1'b0, 1'b1, 1'b1, 13'h0040};
      vecs[8]  = '{8'd127, 8'h80,  2'd0, 1'b0, 13'h0,    6'd1, 5'd0, 1'b0, 1'b1, 1'b1, 13'h0001};
      vecs[9]  = '{8'd10,  8'hF6,  2'd0, 1'b0, 13'h0,    6'd1, 5'd1, 1'b0, 1'b0, 1'b0, 13'h0000};
      vecs[10] = '{8'd40,  8'd0,   2'd1, 1'b1, 13'h0842, 6'd1, 5'd1, 1'b1, 1'b1, 1'b1, 13'h0842};
      vecs[11] = '{8'd0,   8'd40,  2'd3, 1'b1, 13'h1881, 6'd1, 5'd1, 1'b1, 1'b1, 1'b1, 13'h1881};
      vecs[12] = '{8'hD8,  8'd0,   2'd2, 1'b1, 13'h1040, 6'd1, 5'd1, 1'b1, 1'b1, 1'b1, 13'h1040};
      vecs[13] = '{8'd15,  8'hEC,  2'd0, 1'b0, 13'h0,    6'd1, 5'd0, 1'b0, 1'b1, 1'b1, 13'h0001};

      rst        = 1'b1;
      game_start = 1'b0;
      level      = 2'd0;
      tilt_x     = 8'd0;
      tilt_y     = 8'd0;
      tilt_valid = 1'b0;
      tickNeg();
      tickNeg();

      // Reset values.
      checkOutput("rst_ball_x", ball_x, 6'd1);
      checkOutput("rst_ball_y", ball_y, 5'd1);
      checkOutput("rst_addr", wall_rd_addr, 13'd0);
      checkOutput("rst_moving", moving, 1'b0);
      checkOutput("rst_collision", collision, 1'b0);
      checkOutput("rst_at_finish", at_finish, 1'b0);

      // game_start under reset is ignored; the first one afterwards works.
      game_start = 1'b1;
      tickNeg();
      rst        = 1'b0;
      game_start = 1'b0;
      applyTilt(8'd40, 8'd0);
      repeat (6) tickNeg();
      checkOutput("rstprio_moving_idle", moving, 1'b0);
      checkOutput("rstprio_ball_x", ball_x, 6'd1);
      startGame(2'd0);
      checkOutput("rstprio_moving_started", moving, 1'b1);

      // Table of single-step vectors.
      for (int i = 0; i < 14; i++) applyStimulus(i);

      // Two steps right with exact 3-cycle tick-to-update latency.
      doReset();
      applyTilt(8'd40, 8'd0);
      startGame(2'd0);
      coll_seen = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tickNeg();
         if (collision) coll_seen = 1'b1;
         if (k == 6)  checkOutput("run_x_before_update", ball_x, 6'd1);
         if (k == 7)  checkOutput("run_x_step1", ball_x, 6'd2);
         if (k == 13) checkOutput("run_x_hold", ball_x, 6'd2);
         if (k == 14) checkOutput("run_x_step2", ball_x, 6'd3);
      end
      checkOutput("run_ball_y", ball_y, 5'd1);
      checkOutput("run_moving", moving, 1'b1);
      checkOutput("run_no_collision", coll_seen, 1'b0);

      // Left edge: step to x=0, then further steps are blocked silently.
      doReset();
      applyTilt(8'hD8, 8'd0);
      startGame(2'd0);
      coll_seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tickNeg();
         if (collision) coll_seen = 1'b1;
      end
      checkOutput("edge_ball_x", ball_x, 6'd0);
      checkOutput("edge_ball_y", ball_y, 5'd1);
      checkOutput("edge_no_collision", coll_seen, 1'b0);
      checkOutput("edge_addr_unchanged", wall_rd_addr, 13'h0040);

      // Wall hit on level 2: address, one-cycle collision pulse, ball reset.
      doReset();
      wall_mem[13'h1042] = 1'b1;
      applyTilt(8'd40, 8'd0);
      startGame(2'd2);
      waitAddr("wall_addr", 13'h1042);
      checkOutput("wall_coll_lookup", collision, 1'b0);
      tickNeg();
      checkOutput("wall_coll_check", collision, 1'b0);
      tickNeg();
      checkOutput("wall_coll_pulse", collision, 1'b1);
      checkOutput("wall_ball_x", ball_x, 6'd1);
      checkOutput("wall_ball_y", ball_y, 5'd1);
      tickNeg();
      checkOutput("wall_coll_end", collision, 1'b0);
      wall_mem[13'h1042] = 1'b0;

      // Tilt captured mid-step does not change the latched candidate.
      doReset();
      applyTilt(8'd40, 8'd0);
      startGame(2'd0);
      waitAddr("midstep_addr", 13'h0042);
      tilt_x     = 8'hD8;
      tilt_valid = 1'b1;
      tickNeg();
      tilt_valid = 1'b0;
      tickNeg();
      tickNeg();
      checkOutput("midstep_ball_x", ball_x, 6'd2);
      repeat (7) tickNeg();
      checkOutput("midstep_next_step_left", ball_x, 6'd1);

      // game_start during CHECK overrides the pending wall hit.
      doReset();
      wall_mem[13'h0042] = 1'b1;
      applyTilt(8'd40, 8'd0);
      startGame(2'd0);
      waitAddr("abort_addr", 13'h0042);
      tickNeg();
      game_start = 1'b1;
      tickNeg();
      game_start = 1'b0;
      checkOutput("abort_no_collision", collision, 1'b0);
      checkOutput("abort_ball_x", ball_x, 6'd1);
      wall_mem[13'h0042] = 1'b0;

      // Drive the ball to the finish cell (38,28).
      doReset();
      applyTilt(8'd40, 8'd0);
      startGame(2'd0);
      n = 0;
      while (ball_x != 6'd38 && n < 2000) begin
         tickNeg();
         n++;
      end
      checkOutput("finish_reach_x", ball_x, 6'd38);
      applyTilt(8'd0, 8'd40);
      n = 0;
      while (!at_finish && n < 2000) begin
         tickNeg();
         n++;
      end
      checkOutput("finish_at_finish", at_finish, 1'b1);
      checkOutput("finish_ball_x", ball_x, 6'd38);
      checkOutput("finish_ball_y", ball_y, 5'd28);
      checkOutput("finish_moving", moving, 1'b0);
      applyTilt(8'hD8, 8'd0);
      repeat (20) tickNeg();
      checkOutput("finish_hold_x", ball_x, 6'd38);
      checkOutput("finish_hold_y", ball_y, 5'd28);
      checkOutput("finish_hold_flag", at_finish, 1'b1);
      startGame(2'd0);
      checkOutput("restart_at_finish", at_finish, 1'b0);
      checkOutput("restart_ball_x", ball_x, 6'd1);
      checkOutput("restart_ball_y", ball_y, 5'd1);

      // Reset asserted during CHECK with a wall present.
      doReset();
      wall_mem[13'h1042] = 1'b1;
      applyTilt(8'd40, 8'd0);
      startGame(2'd2);
      waitAddr("rstchk_addr_wait", 13'h1042);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rstchk_collision", collision, 1'b0);
      checkOutput("rstchk_addr", wall_rd_addr, 13'd0);
      checkOutput("rstchk_ball_x", ball_x, 6'd1);
      checkOutput("rstchk_ball_y", ball_y, 5'd1);
      checkOutput("rstchk_moving", moving, 1'b0);
      checkOutput("rstchk_at_finish", at_finish, 1'b0);
      @(negedge clk);
      tickNeg();
      checkOutput("rstchk_collision_held", collision, 1'b0);
      rst = 1'b0;
      tickNeg();
      checkOutput("rstchk_collision_after", collision, 1'b0);
      checkOutput("rstchk_moving_after", moving, 1'b0);
      wall_mem[13'h1042] = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ball_tracker.md
BALL_TRACKER -- requirements
Module: ball_tracker

Interface
REQ-001 Parameter STEP_DIV, default 2500000: clk cycles between movement ticks (20 steps/s at 50 MHz).
REQ-002 Parameter DEADZONE, default 16: tilt magnitude below this counts as level (no motion).
REQ-003 Parameter GRID_W, default 40, and GRID_H, default 30: maze size in cells.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 game_start  in  1  one-cycle pulse from the gameplay controller; loads the start cell and enables motion.
REQ-007 level  in  2  selected level; sampled on game_start and held internally.
REQ-008 tilt_x, tilt_y  in  8 each  signed two's-complement accelerometer readings.
REQ-009 tilt_valid  in  1  tilt_x/tilt_y valid this cycle; captured into holding registers only when high.
REQ-010 wall_rd_addr  out  13  maze memory address {level_q[1:0], cand_y[4:0], cand_x[5:0]}.
REQ-011 wall_rd_data  in  1  wall bit for the previous cycle's wall_rd_addr (1-cycle read latency); 1 = wall.
REQ-012 ball_x  out  6 and ball_y  out  5: current ball cell.
REQ-013 moving  out  1  high while captured tilt exceeds DEADZONE on either axis and tracker is enabled.
REQ-014 collision  out  1  one-cycle pulse on a wall hit.
REQ-015 at_finish  out  1  level signal, high while the ball sits on the finish cell (GRID_W-2, GRID_H-2).

Function
REQ-016 FSM states: IDLE, WAIT_TICK, LOOKUP, CHECK, UPDATE, DONE.
REQ-017 IDLE: outputs hold; game_start -> load ball=(1,1), latch level, clear tick counter, go WAIT_TICK.
REQ-018 WAIT_TICK: tick counter increments each cycle; at STEP_DIV-1 it wraps to 0; if moving, go LOOKUP, else remain.
REQ-019 Direction: |tilt_x| >= |tilt_y| selects X axis, else Y; sign selects +1/-1; ties choose X; |-128| treated as 128 (9-bit magnitude compare).
REQ-020 LOOKUP: compute candidate cell, drive wall_rd_addr, go CHECK; candidate fixed for the step.
REQ-021 Candidate outside grid (x<0, x>GRID_W-1, y<0, y>GRID_H-1) is blocked: no move, no collision, no memory read used, return WAIT_TICK.
REQ-022 CHECK: wall_rd_data=1 -> collision pulse, ball=(1,1), go WAIT_TICK; else go UPDATE.
REQ-023 UPDATE: ball <= candidate; if candidate equals finish cell go DONE, else WAIT_TICK.
REQ-024 DONE: at_finish high, no motion, moving forced low; game_start restarts as in REQ-017.
REQ-025 game_start in any state other than IDLE/DONE aborts the step in progress and reloads start cell; it overrides a same-cycle collision or update.
REQ-026 At most one cell of movement per tick; no diagonal motion.
REQ-027 Movement tick to updated ball_x/ball_y latency: exactly 3 cycles (LOOKUP, CHECK, UPDATE).
REQ-028 tilt_valid low keeps previous captured tilt; new capture mid-step does not alter the current candidate.

Reset
REQ-029 rst high asynchronously forces: state IDLE, ball_x=1, ball_y=1, level_q=0, tick counter=0, tilt regs=0, wall_rd_addr=0, moving=0, collision=0, at_finish=0.
REQ-030 rst takes priority over game_start; first game_start after rst release is honoured.

Verification
REQ-031 STEP_DIV=4, game_start, tilt_x=+40, tilt_y=0, all memory 0 -> ball_x 1->2->3 one step per tick, ball_y=1, moving=1, collision never.
REQ-032 tilt_x=-40 at ball (1,1) with no walls -> candidate x=0 read allowed; next step x=-1 blocked, ball stays (0,1), no collision.
REQ-033 Wall at (2,1) level 2, tilt_x=+40 -> wall_rd_addr=0x1042 (level 2, y 1, x 2), collision 1-cycle pulse, ball returns (1,1).
REQ-034 tilt_x=+10, tilt_y=-10 (both < DEADZONE) -> moving=0, no reads, ball unchanged over 20 ticks; tilt_x=30,tilt_y=30 -> X axis chosen.
REQ-035 Preload ball path to (38,28) -> at_finish=1, state DONE, tilt ignored; game_start -> at_finish=0, ball=(1,1).
REQ-036 Assert rst during CHECK with wall_rd_data=1 -> no collision pulse, all outputs at REQ-029 values.
